// File: rtl/viterbi_pkg.sv
// Shared constants, FSM encoding and encoder branch function for the K=7 rate-1/2 Viterbi decoder.
package viterbi_pkg;

  localparam int unsigned K          = 7;
  localparam int unsigned NUM_STATES = 64;
  localparam logic [6:0]  G0         = 7'o133;
  localparam logic [6:0]  G1         = 7'o171;

  typedef enum logic [1:0] {ACS, FIND, TRACE, OUT} state_t;

  // Generator MSB taps the current input u, LSB taps the oldest bit d6 = state[5].
  function automatic logic [1:0] branch_out(input logic [5:0] state, input logic u);
    logic [6:0] taps;
    taps = {u, state[0], state[1], state[2], state[3], state[4], state[5]};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/viterbi_survivor_ram.sv
// Survivor decision memory: one 64-bit word per trellis step, sync write, async read.
module viterbi_survivor_ram #(
  parameter int N_OUT = 48,
  parameter int AW    = $clog2(N_OUT)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [N_OUT];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_block_decoder.sv
// Block Viterbi decoder: full 64-state ACS per accepted pair, best-state search,
// traceback into an output buffer, then in-order streaming with backpressure.
module viterbi_block_decoder
  import viterbi_pkg::*;
#(
  parameter int N_OUT      = 48,
  parameter int SOFT_W     = 1,
  parameter int METRIC_W   = 16,
  parameter int TERMINATED = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              EN,
  input  logic              In_valid,
  input  logic [SOFT_W-1:0] In_a,
  input  logic [SOFT_W-1:0] In_b,
  output logic              In_ready,
  output logic              Out,
  output logic              Out_valid,
  output logic              Out_last,
  input  logic              Out_ready,
  output logic              Busy
);

  localparam int AW = $clog2(N_OUT);
  localparam logic [AW-1:0]       LAST   = AW'(N_OUT - 1);
  localparam logic [SOFT_W-1:0]   SMAX   = '1;
  localparam logic [METRIC_W-1:0] M_INIT = {2'b01, {(METRIC_W-2){1'b0}}};

  state_t              st;
  logic [METRIC_W-1:0] metric     [NUM_STATES];
  logic [METRIC_W-1:0] new_metric [NUM_STATES];
  logic [63:0]         dec;
  logic [63:0]         surv_word;
  logic [AW-1:0]       step, k, ptr, ptr_nxt;
  logic [5:0]          idx, best_s, tb_state;
  logic [METRIC_W-1:0] best_m;
  logic [N_OUT-1:0]    obuf;
  logic                accept, better;

  function automatic logic [METRIC_W-1:0] cost(input logic e, input logic [SOFT_W-1:0] x);
    return METRIC_W'(e ? SMAX - x : x);
  endfunction

  function automatic logic [METRIC_W-1:0] bmetric(input logic [5:0] p, input logic u,
                                                  input logic [SOFT_W-1:0] a,
                                                  input logic [SOFT_W-1:0] b);
    logic [1:0] e;
    e = branch_out(p, u);
    return cost(e[1], a) + cost(e[0], b);
  endfunction

  assign In_ready = EN & ~Reset & (st == ACS);
  assign accept   = In_valid & In_ready;
  assign Busy     = (st != ACS);
  assign ptr_nxt  = ptr + 1'b1;
  assign better   = (idx == 6'd0) || (metric[idx] < best_m);

  // Next state n = {s[4:0], u}, so u = n[0] and predecessors are {b, n[5:1]}.
  always_comb begin
    logic [5:0]          nv, p0, p1;
    logic [METRIC_W-1:0] c0, c1;
    nv  = '0;
    p0  = '0;
    p1  = '0;
    c0  = '0;
    c1  = '0;
    dec = '0;
    for (int unsigned n = 0; n < NUM_STATES; n++) begin
      nv            = n[5:0];
      p0            = {1'b0, nv[5:1]};
      p1            = {1'b1, nv[5:1]};
      c0            = metric[p0] + bmetric(p0, nv[0], In_a, In_b);
      c1            = metric[p1] + bmetric(p1, nv[0], In_a, In_b);
      dec[n]        = (c1 < c0);
      new_metric[n] = dec[n] ? c1 : c0;
    end
  end

  viterbi_survivor_ram #(.N_OUT(N_OUT), .AW(AW)) u_surv (
    .clk   (Clk),
    .we    (accept),
    .waddr (step),
    .wdata (dec),
    .raddr (k),
    .rdata (surv_word)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st        <= ACS;
      step      <= '0;
      k         <= '0;
      ptr       <= '0;
      idx       <= '0;
      best_s    <= '0;
      best_m    <= '0;
      tb_state  <= '0;
      Out       <= 1'b0;
      Out_valid <= 1'b0;
      Out_last  <= 1'b0;
      for (int unsigned n = 0; n < NUM_STATES; n++)
        metric[n] <= (n == 0) ? '0 : M_INIT;
    end else if (EN) begin
      unique case (st)
        ACS: begin
          if (accept) begin
            for (int unsigned n = 0; n < NUM_STATES; n++)
              metric[n] <= new_metric[n];
            if (step == LAST) begin
              step     <= '0;
              k        <= LAST;
              idx      <= '0;
              tb_state <= '0;
              st       <= (TERMINATED != 0) ? TRACE : FIND;
            end else begin
              step <= step + 1'b1;
            end
          end
        end
        FIND: begin
          if (better) begin
            best_m <= metric[idx];
            best_s <= idx;
          end
          if (idx == 6'd63) begin
            tb_state <= better ? idx : best_s;
            st       <= TRACE;
          end
          idx <= idx + 1'b1;
        end
        TRACE: begin
          obuf[k]  <= tb_state[0];
          tb_state <= {surv_word[tb_state], tb_state[5:1]};
          // Address 0 is written this cycle, so the first output bit bypasses the buffer.
          if (k == '0) begin
            st        <= OUT;
            ptr       <= '0;
            Out       <= tb_state[0];
            Out_valid <= 1'b1;
            Out_last  <= 1'b0;
          end else begin
            k <= k - 1'b1;
          end
        end
        OUT: begin
          if (Out_ready) begin
            if (ptr == LAST) begin
              Out       <= 1'b0;
              Out_valid <= 1'b0;
              Out_last  <= 1'b0;
              ptr       <= '0;
              st        <= ACS;
              for (int unsigned n = 0; n < NUM_STATES; n++)
                metric[n] <= (n == 0) ? '0 : M_INIT;
            end else begin
              ptr      <= ptr_nxt;
              Out      <= obuf[ptr_nxt];
              Out_last <= (ptr_nxt == LAST);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_block_decoder.sv
// Directed bench: hard/non-terminated and soft/terminated instances driven from a vector table.
module tb_viterbi_block_decoder;

  localparam int N = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst, en, in_valid, out_ready;
  logic       in_a0, in_b0;
  logic [2:0] in_a1, in_b1;
  logic       in_ready0, out0, out_valid0, out_last0, busy0;
  logic       in_ready1, out1, out_valid1, out_last1, busy1;

  viterbi_block_decoder #(.N_OUT(N), .SOFT_W(1), .METRIC_W(16), .TERMINATED(0)) u_hard (
    .Clk(clk), .Reset(rst[0]), .EN(en[0]), .In_valid(in_valid[0]), .In_a(in_a0), .In_b(in_b0),
    .In_ready(in_ready0), .Out(out0), .Out_valid(out_valid0), .Out_last(out_last0),
    .Out_ready(out_ready[0]), .Busy(busy0)
  );

  viterbi_block_decoder #(.N_OUT(N), .SOFT_W(3), .METRIC_W(16), .TERMINATED(1)) u_soft (
    .Clk(clk), .Reset(rst[1]), .EN(en[1]), .In_valid(in_valid[1]), .In_a(in_a1), .In_b(in_b1),
    .In_ready(in_ready1), .Out(out1), .Out_valid(out_valid1), .Out_last(out_last1),
    .Out_ready(out_ready[1]), .Busy(busy1)
  );

  typedef struct {
    int          sel;
    logic [47:0] data;
    logic [47:0] errm;
    logic [47:0] erm;
    int          rdy_mode;
    logic [47:0] exp_bits;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic rd_ov(input int s);   return s ? out_valid1 : out_valid0; endfunction
  function automatic logic rd_ob(input int s);   return s ? out1 : out0;             endfunction
  function automatic logic rd_ol(input int s);   return s ? out_last1 : out_last0;   endfunction
  function automatic logic rd_ir(input int s);   return s ? in_ready1 : in_ready0;   endfunction
  function automatic logic rd_busy(input int s); return s ? busy1 : busy0;           endfunction

  task automatic set_pair(input int s, input logic a, input logic b, input logic er);
    if (s == 0) begin
      in_a0 = a;
      in_b0 = b;
    end else if (er) begin
      in_a1 = 3'd3;
      in_b1 = 3'd4;
    end else begin
      in_a1 = a ? 3'd7 : 3'd0;
      in_b1 = b ? 3'd7 : 3'd0;
    end
  endtask

  task automatic send(input int s, input logic [47:0] data, input logic [47:0] errm,
                      input logic [47:0] erm, output int c0, output bit to);
    logic [6:0] h;
    logic       a, b;
    int         g;
    h  = '0;
    to = 1'b0;
    for (int i = 0; i < N; i++) begin
      h = {data[i], h[6:1]};
      a = (^(h & 7'o133)) ^ errm[i];
      b = ^(h & 7'o171);
      set_pair(s, a, b, erm[i]);
      in_valid[s] = 1'b1;
      g = 0;
      while (!rd_ir(s) && g < 200) begin
        @(posedge clk); #1;
        g++;
      end
      if (g >= 200) to = 1'b1;
      @(posedge clk); #1;
    end
    in_valid[s] = 1'b0;
    c0 = cyc;
  endtask

  task automatic recv(input int s, input int mode, input int c0, output logic [47:0] got,
                      output int lat, output int cnt, output int lastpos, output int nlast);
    int   g;
    bit   dropped;
    logic hv, hb;
    got = '0; lat = -1; cnt = 0; lastpos = -1; nlast = 0; g = 0; dropped = 0;
    out_ready[s] = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    while (cnt < N && g < 3000) begin
      if (rd_ov(s) && lat < 0) lat = cyc - c0 + 1;
      if (mode == 2 && !dropped && cnt == 20 && rd_ov(s)) begin
        hv = rd_ov(s);
        hb = rd_ob(s);
        en[s] = 1'b0;
        out_ready[s] = 1'b1;
        repeat (5) begin
          @(posedge clk); #1;
          g++;
          check("en_low_hold_valid", rd_ov(s), hv);
          check("en_low_hold_bit", rd_ob(s), hb);
        end
        en[s] = 1'b1;
        dropped = 1;
      end
      if (rd_ov(s) && out_ready[s] && en[s]) begin
        got[cnt] = rd_ob(s);
        if (rd_ol(s)) begin
          lastpos = cnt;
          nlast++;
        end
        cnt++;
      end
      @(posedge clk); #1;
      g++;
      out_ready[s] = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    out_ready[s] = 1'b1;
  endtask

  task automatic run_block(input string tag, input int s, input logic [47:0] data,
                           input logic [47:0] errm, input logic [47:0] erm, input int mode,
                           input logic [47:0] exp_bits, input int exp_lat);
    int          c0, lat, cnt, lastpos, nlast;
    bit          to;
    logic [47:0] got;
    send(s, data, errm, erm, c0, to);
    check({tag, "_send_timeout"}, to, 0);
    recv(s, mode, c0, got, lat, cnt, lastpos, nlast);
    check({tag, "_bit_count"}, cnt, N);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, got, exp_bits);
    check({tag, "_last_pos"}, lastpos, N - 1);
    check({tag, "_last_count"}, nlast, 1);
    check({tag, "_valid_drops"}, rd_ov(s), 0);
    check({tag, "_ready_back"}, rd_ir(s), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [47:0] prbs, prbs_t;
    logic [6:0]  lf;
    int          c0;
    bit          to, seen;

    lf = 7'h7f;
    for (int i = 0; i < N; i++) begin
      prbs[i] = lf[6] ^ lf[5];
      lf      = {lf[5:0], lf[6] ^ lf[5]};
    end
    prbs_t         = prbs;
    prbs_t[47:42]  = '0;

    vecs[0] = '{0, 48'h0, 48'h0, 48'h0, 0, 48'h0, 113};
    vecs[1] = '{0, prbs, 48'h0, 48'h0, 1, prbs, 113};
    vecs[2] = '{0, prbs, (48'd1 << 5) | (48'd1 << 20), 48'h0, 2, prbs, 113};
    vecs[3] = '{1, prbs_t, 48'h0, 48'h0, 0, prbs_t, 49};
    vecs[4] = '{1, prbs_t, (48'd1 << 5) | (48'd1 << 20) | (48'd1 << 40), 48'h0, 1, prbs_t, 49};
    vecs[5] = '{1, prbs_t, 48'h0, (48'd1 << 10) | (48'd1 << 11), 0, prbs_t, 49};
    vecs[6] = '{1, 48'h0, 48'h0, 48'h0, 1, 48'h0, 49};

    rst = 2'b11; en = 2'b11; in_valid = 2'b00; out_ready = 2'b11;
    in_a0 = 1'b0; in_b0 = 1'b0; in_a1 = '0; in_b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_hard", in_ready0, 0);
    check("rst_in_ready_soft", in_ready1, 0);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_bit", out0, 0);
    check("rst_out_last", out_last0, 0);
    check("rst_busy_hard", busy0, 0);
    check("rst_busy_soft", busy1, 0);
    rst = 2'b00;
    @(posedge clk); #1;
    check("post_rst_ready_hard", in_ready0, 1);
    check("post_rst_ready_soft", in_ready1, 1);

    for (int v = 0; v < 7; v++)
      run_block($sformatf("vec%0d", v), vecs[v].sel, vecs[v].data, vecs[v].errm, vecs[v].erm,
                vecs[v].rdy_mode, vecs[v].exp_bits, vecs[v].exp_lat);

    // Abort a block in TRACE, then confirm nothing leaks out and the next block is clean.
    send(0, prbs, 48'h0, 48'h0, c0, to);
    check("abort_send_timeout", to, 0);
    repeat (70) @(posedge clk);
    #1;
    check("abort_busy_in_trace", busy0, 1);
    rst[0] = 1'b1;
    #1;
    check("abort_ready_in_reset", in_ready0, 0);
    @(posedge clk); #1;
    check("abort_ready_reset_held", in_ready0, 0);
    check("abort_busy_cleared", busy0, 0);
    check("abort_valid_cleared", out_valid0, 0);
    rst[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_ready_after", in_ready0, 1);
    seen = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (out_valid0) seen = 1;
    end
    check("abort_no_output", seen, 0);
    run_block("fresh", 0, ~prbs, 48'h0, 48'h0, 0, ~prbs, 113);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
